// File: rtl/coreriscv_axi4_meta_pkg.sv
// Shared types and constants for the L1 metadata (tag) read pipeline.
// Holds array geometry, the response payload struct and the response-buffer depth.
package coreriscv_axi4_meta_pkg;

    localparam int IDX_W           = 7;
    localparam int TAG_W           = 20;
    localparam int SRC_W           = 2;
    localparam int META_RESP_DEPTH = 2;
    localparam int META_CNT_W      = 2;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             way_en;
        logic [SRC_W-1:0] src;
    } meta_resp_t;

    // Slots still free once the in-flight S2 entry lands and any same-cycle pop leaves.
    function automatic logic credit_ok(input logic [META_CNT_W-1:0] count,
                                       input logic                  s2_valid,
                                       input logic                  pop);
        logic [META_CNT_W:0] occ;
        occ = {1'b0, count} + {{META_CNT_W{1'b0}}, s2_valid} - {{META_CNT_W{1'b0}}, pop};
        return occ < (META_CNT_W + 1)'(META_RESP_DEPTH);
    endfunction

endpackage

// File: rtl/coreriscv_axi4_meta_resp_fifo.sv
// Two-entry response buffer for the metadata read pipe.
// 1-bit wrapping pointers with an explicit occupancy count for full/empty.
module coreriscv_axi4_meta_resp_fifo
    import coreriscv_axi4_meta_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  meta_resp_t            push_data_i,
    input  logic                  pop_i,
    output meta_resp_t            head_o,
    output logic [META_CNT_W-1:0] count_o,
    output logic                  empty_o
);

    meta_resp_t            mem_q [META_RESP_DEPTH];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [META_CNT_W-1:0] count_q, count_d;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == META_CNT_W'(META_RESP_DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Upstream credit keeps push-at-full from happening; the guard is defensive.
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            for (int i = 0; i < META_RESP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/coreriscv_axi4_meta_read_pipe.sv
// Metadata tag-array read pipe: issue (S1) -> SRAM capture (S2) -> 2-entry response buffer.
// Optional same-cycle S2 forwarding when the buffer is empty: CORERISCV_AXI4_META_BYPASS_EN.
module coreriscv_axi4_meta_read_pipe
    import coreriscv_axi4_meta_pkg::*;
(
    input  logic             clk,
    input  logic             reset,

    output logic             io_in_ready,
    input  logic             io_in_valid,
    input  logic [IDX_W-1:0] io_in_bits_idx,
    input  logic             io_in_bits_way_en,
    input  logic [SRC_W-1:0] io_in_chosen,

    input  logic             io_wr_valid,
    output logic             io_wr_ready,
    input  logic [IDX_W-1:0] io_wr_bits_idx,
    input  logic [TAG_W-1:0] io_wr_bits_tag,

    output logic             sram_en,
    output logic             sram_we,
    output logic [IDX_W-1:0] sram_addr,
    output logic [TAG_W-1:0] sram_wdata,
    input  logic [TAG_W-1:0] sram_rdata,

    output logic             io_resp_valid,
    input  logic             io_resp_ready,
    output logic [TAG_W-1:0] io_resp_bits_tag,
    output logic             io_resp_bits_way_en,
    output logic [SRC_W-1:0] io_resp_bits_src
);

    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_way_q, s2_way_d;
    logic [SRC_W-1:0]      s2_src_q, s2_src_d;

    logic                  rd_fire;
    logic                  resp_pop;
    logic                  bypass_act;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic [META_CNT_W-1:0] fifo_count;
    meta_resp_t            s2_entry;
    meta_resp_t            fifo_head;
    meta_resp_t            resp_sel;

    assign io_wr_ready = 1'b1;
    assign resp_pop    = io_resp_valid & io_resp_ready;
    assign io_in_ready = ~io_wr_valid & credit_ok(fifo_count, s2_valid_q, resp_pop);
    assign rd_fire     = io_in_valid & io_in_ready;

    // Writes own the single SRAM port; an idle port drives zeros rather than X.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (io_wr_valid) begin
            sram_en    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = io_wr_bits_idx;
            sram_wdata = io_wr_bits_tag;
        end else if (rd_fire) begin
            sram_en   = 1'b1;
            sram_addr = io_in_bits_idx;
        end
    end

    always_comb begin
        s2_valid_d = rd_fire;
        s2_way_d   = s2_way_q;
        s2_src_d   = s2_src_q;
        if (rd_fire) begin
            s2_way_d = io_in_bits_way_en;
            s2_src_d = io_in_chosen;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_way_q   <= 1'b0;
            s2_src_q   <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_way_q   <= s2_way_d;
            s2_src_q   <= s2_src_d;
        end
    end

    assign s2_entry.tag    = sram_rdata;
    assign s2_entry.way_en = s2_way_q;
    assign s2_entry.src    = s2_src_q;

`ifdef CORERISCV_AXI4_META_BYPASS_EN
    assign bypass_act = fifo_empty & s2_valid_q;
`else
    assign bypass_act = 1'b0;
`endif

    // A forwarded entry that is consumed immediately never occupies a buffer slot.
    assign fifo_push = s2_valid_q & ~(bypass_act & io_resp_ready);
    assign fifo_pop  = io_resp_ready & ~fifo_empty;

    coreriscv_axi4_meta_resp_fifo u_resp_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (s2_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        resp_sel = '0;
        if (bypass_act) begin
            resp_sel = s2_entry;
        end else if (!fifo_empty) begin
            resp_sel = fifo_head;
        end
    end

    assign io_resp_valid       = ~fifo_empty | bypass_act;
    assign io_resp_bits_tag    = resp_sel.tag;
    assign io_resp_bits_way_en = resp_sel.way_en;
    assign io_resp_bits_src    = resp_sel.src;

endmodule

// File: tb/tb_coreriscv_axi4_meta_read_pipe.sv
// Self-checking bench for coreriscv_axi4_meta_read_pipe: directed steps then random traffic,
// checked against a queue-based model of request order, latency and credit.
module tb_coreriscv_axi4_meta_read_pipe;
    import coreriscv_axi4_meta_pkg::*;

`ifdef CORERISCV_AXI4_META_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             io_in_ready;
    logic             io_in_valid;
    logic [IDX_W-1:0] io_in_bits_idx;
    logic             io_in_bits_way_en;
    logic [SRC_W-1:0] io_in_chosen;
    logic             io_wr_valid;
    logic             io_wr_ready;
    logic [IDX_W-1:0] io_wr_bits_idx;
    logic [TAG_W-1:0] io_wr_bits_tag;
    logic             sram_en;
    logic             sram_we;
    logic [IDX_W-1:0] sram_addr;
    logic [TAG_W-1:0] sram_wdata;
    logic [TAG_W-1:0] sram_rdata = '0;
    logic             io_resp_valid;
    logic             io_resp_ready;
    logic [TAG_W-1:0] io_resp_bits_tag;
    logic             io_resp_bits_way_en;
    logic [SRC_W-1:0] io_resp_bits_src;

    always #5 clk = ~clk;

    coreriscv_axi4_meta_read_pipe dut (
        .clk                 (clk),
        .reset               (reset),
        .io_in_ready         (io_in_ready),
        .io_in_valid         (io_in_valid),
        .io_in_bits_idx      (io_in_bits_idx),
        .io_in_bits_way_en   (io_in_bits_way_en),
        .io_in_chosen        (io_in_chosen),
        .io_wr_valid         (io_wr_valid),
        .io_wr_ready         (io_wr_ready),
        .io_wr_bits_idx      (io_wr_bits_idx),
        .io_wr_bits_tag      (io_wr_bits_tag),
        .sram_en             (sram_en),
        .sram_we             (sram_we),
        .sram_addr           (sram_addr),
        .sram_wdata          (sram_wdata),
        .sram_rdata          (sram_rdata),
        .io_resp_valid       (io_resp_valid),
        .io_resp_ready       (io_resp_ready),
        .io_resp_bits_tag    (io_resp_bits_tag),
        .io_resp_bits_way_en (io_resp_bits_way_en),
        .io_resp_bits_src    (io_resp_bits_src)
    );

    // Synchronous single-port tag array attached to the DUT.
    logic [TAG_W-1:0] sram_mem [2**IDX_W];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) sram_mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= sram_mem[sram_addr];
        end
    end

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             way;
        logic [SRC_W-1:0] src;
        int               acc;
    } exp_t;

    exp_t             q[$];
    logic [TAG_W-1:0] shadow [2**IDX_W];
    int               cyc;
    int               n_vec;
    int               n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, check just after, update the model at posedge.
    task automatic step(input logic wv, input logic [IDX_W-1:0] widx, input logic [TAG_W-1:0] wtag,
                        input logic iv, input logic [IDX_W-1:0] ridx, input logic rway,
                        input logic [SRC_W-1:0] rsrc, input logic rr);
        logic vis, pop, rdy, fire;
        exp_t e;
        @(negedge clk);
        io_wr_valid       = wv;
        io_wr_bits_idx    = widx;
        io_wr_bits_tag    = wtag;
        io_in_valid       = iv;
        io_in_bits_idx    = ridx;
        io_in_bits_way_en = rway;
        io_in_chosen      = rsrc;
        io_resp_ready     = rr;
        #1;
        vis  = (q.size() > 0) && (cyc >= q[0].acc + LAT);
        pop  = vis & rr;
        rdy  = !wv && ((q.size() - (pop ? 1 : 0)) < 2);
        fire = iv & rdy;
        chk("in_ready", 32'(io_in_ready), 32'(rdy));
        chk("wr_ready", 32'(io_wr_ready), 32'd1);
        chk("resp_valid", 32'(io_resp_valid), 32'(vis));
        if (vis) begin
            chk("resp_tag", 32'(io_resp_bits_tag), 32'(q[0].tag));
            chk("resp_way", 32'(io_resp_bits_way_en), 32'(q[0].way));
            chk("resp_src", 32'(io_resp_bits_src), 32'(q[0].src));
        end
        chk("sram_en", 32'(sram_en), 32'(wv | fire));
        chk("sram_we", 32'(sram_we), 32'(wv));
        chk("sram_addr", 32'(sram_addr), wv ? 32'(widx) : (fire ? 32'(ridx) : 32'd0));
        chk("sram_wdata", 32'(sram_wdata), wv ? 32'(wtag) : 32'd0);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (fire) begin
            e.tag = shadow[ridx];
            e.way = rway;
            e.src = rsrc;
            e.acc = cyc;
            q.push_back(e);
        end
        if (wv) shadow[widx] = wtag;
        cyc++;
    endtask

    task automatic idle(input logic rr);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, rr);
    endtask

    task automatic wr(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag);
        step(1'b1, idx, tag, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic rd(input logic [IDX_W-1:0] idx, input logic way, input logic [SRC_W-1:0] src,
                      input logic rr);
        step(1'b0, '0, '0, 1'b1, idx, way, src, rr);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        for (int i = 0; i < 2**IDX_W; i++) begin
            sram_mem[i] = '0;
            shadow[i]   = '0;
        end
        reset             = 1'b1;
        io_in_valid       = 1'b0;
        io_in_bits_idx    = '0;
        io_in_bits_way_en = 1'b0;
        io_in_chosen      = '0;
        io_wr_valid       = 1'b0;
        io_wr_bits_idx    = '0;
        io_wr_bits_tag    = '0;
        io_resp_ready     = 1'b0;

        // Reset values
        #12;
        chk("rst_resp_valid", 32'(io_resp_valid), 32'd0);
        chk("rst_resp_tag", 32'(io_resp_bits_tag), 32'd0);
        chk("rst_resp_way", 32'(io_resp_bits_way_en), 32'd0);
        chk("rst_resp_src", 32'(io_resp_bits_src), 32'd0);
        chk("rst_sram_en", 32'(sram_en), 32'd0);
        chk("rst_sram_we", 32'(sram_we), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_sram_wdata", 32'(sram_wdata), 32'd0);
        chk("rst_in_ready", 32'(io_in_ready), 32'd1);
        chk("rst_wr_ready", 32'(io_wr_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Single read after write
        wr(7'd5, 20'hABCDE);
        rd(7'd5, 1'b1, 2'd2, 1'b1);
        repeat (3) idle(1'b1);

        // Streaming: 8 back-to-back reads
        for (int i = 0; i < 8; i++) wr(7'(i), 20'($urandom));
        for (int i = 0; i < 8; i++) rd(7'(i), 1'($urandom), 2'($urandom_range(0, 2)), 1'b1);
        repeat (3) idle(1'b1);

        // Backpressure: only two of four reads accepted, then drain and resume
        for (int i = 0; i < 4; i++) rd(7'(i + 2), 1'b1, 2'(i % 3), 1'b0);
        repeat (2) idle(1'b0);
        repeat (3) idle(1'b1);
        for (int i = 0; i < 3; i++) rd(7'(i + 4), 1'b0, 2'd1, 1'b1);
        repeat (3) idle(1'b1);

        // Write priority over a coincident read, then same-index read sees new tag
        wr(7'd9, 20'h11111);
        step(1'b1, 7'd9, 20'h5A5A5, 1'b1, 7'd9, 1'b1, 2'd0, 1'b1);
        rd(7'd9, 1'b1, 2'd0, 1'b1);
        repeat (3) idle(1'b1);

        // Reset mid-flight with one buffered entry and one in S2
        rd(7'd1, 1'b0, 2'd1, 1'b0);
        rd(7'd2, 1'b1, 2'd2, 1'b0);
        @(negedge clk);
        io_in_valid   = 1'b0;
        io_wr_valid   = 1'b0;
        io_resp_ready = 1'b0;
        #1;
        chk("pre_rst_resp_valid", 32'(io_resp_valid), 32'((q.size() > 0) && (cyc >= q[0].acc + LAT)));
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_resp_valid", 32'(io_resp_valid), 32'd0);
        chk("midrst_in_ready", 32'(io_in_ready), 32'd1);
        chk("midrst_sram_en", 32'(sram_en), 32'd0);
        q.delete();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        cyc++;
        rd(7'd5, 1'b0, 2'd1, 1'b1);
        repeat (4) idle(1'b1);

        // Random traffic with a small index range to provoke read-after-write collisions
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0, 7'($urandom_range(0, 15)), 20'($urandom),
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 7'($urandom_range(0, 15)), 1'($urandom),
                 2'($urandom_range(0, 2)), ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
        end
        repeat (6) idle(1'b1);
        chk("drained", 32'(q.size()), 32'd0);
        chk("final_resp_valid", 32'(io_resp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
